// File: rtl/present_pkg.sv
// PRESENT-80 key schedule shared types and constants.
// Used by the key schedule controller and its key_update block.
package present_pkg;

  localparam int KEY_W      = 80;
  localparam int RK_W       = 64;
  localparam int NUM_ROUNDS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [5:0] round_t;

endpackage

// File: rtl/present_key_update.sv
// PRESENT-80 key update: rotate left 61, S-box on top nibble,
// round counter XORed into bits 19:15.
module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [4:0]       cnt_i,
  output logic [KEY_W-1:0] key_o
);

  logic [KEY_W-1:0] w_rot;
  logic [3:0]       w_sb;

  assign w_rot = {key_i[18:0], key_i[79:19]};

  always_comb begin
    w_sb = 4'h0;
    case (w_rot[79:76])
      4'h0: w_sb = 4'hC;
      4'h1: w_sb = 4'h5;
      4'h2: w_sb = 4'h6;
      4'h3: w_sb = 4'hB;
      4'h4: w_sb = 4'h9;
      4'h5: w_sb = 4'h0;
      4'h6: w_sb = 4'hA;
      4'h7: w_sb = 4'hD;
      4'h8: w_sb = 4'h3;
      4'h9: w_sb = 4'hE;
      4'hA: w_sb = 4'hF;
      4'hB: w_sb = 4'h8;
      4'hC: w_sb = 4'h4;
      4'hD: w_sb = 4'h7;
      4'hE: w_sb = 4'h1;
      default: w_sb = 4'h2;
    endcase
  end

  assign key_o = {
    w_sb,
    w_rot[75:20],
    w_rot[19:15] ^ cnt_i,
    w_rot[14:0]
  };

endmodule

// File: rtl/present_key_sched_ctrl.sv
// PRESENT-80 key schedule sequencer: loads a user key and hands
// out round keys K1..K32 one per valid/ready handshake.
module present_key_sched_ctrl
  import present_pkg::*;
#(
  parameter int NUM_ROUNDS = present_pkg::NUM_ROUNDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic [RK_W-1:0]  rk_o,
  output logic [5:0]       round_o,
  output logic             last_o,
  output logic             done_o
);

  localparam round_t LAST_R = round_t'(NUM_ROUNDS);

  state_e           r_state;
  state_e           w_state_nx;
  logic [KEY_W-1:0] r_key;
  logic [KEY_W-1:0] w_key_nx;
  logic [KEY_W-1:0] w_key_upd;
  round_t           r_round;
  round_t           w_round_nx;
  logic             r_done;
  logic             w_done_nx;
  logic             w_run;
  logic             w_hs;
  logic             w_last;

  present_key_update u_key_update (
    .key_i (r_key),
    .cnt_i (r_round[4:0]),
    .key_o (w_key_upd)
  );

  assign w_run  = (r_state == RUN);
  assign w_hs   = w_run & rk_ready_i;
  assign w_last = (r_round == LAST_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_key   <= w_key_nx;
      r_round <= w_round_nx;
      r_done  <= w_done_nx;
    end
  end

  // abort outranks both a pending start and a handshake
  always_comb begin
    w_state_nx = r_state;
    w_key_nx   = r_key;
    w_round_nx = r_round;
    w_done_nx  = 1'b0;
    if (abort_i) begin
      w_state_nx = IDLE;
      w_key_nx   = '0;
      w_round_nx = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            w_state_nx = RUN;
            w_key_nx   = key_i;
            w_round_nx = round_t'(1);
          end
        end
        RUN: begin
          if (w_hs && w_last) begin
            w_state_nx = IDLE;
            w_round_nx = '0;
            w_done_nx  = 1'b1;
          end else if (w_hs) begin
            w_key_nx   = w_key_upd;
            w_round_nx = r_round + round_t'(1);
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign busy_o     = w_run;
  assign rk_valid_o = w_run;
  assign rk_o       = r_key[KEY_W-1:KEY_W-RK_W];
  assign round_o    = r_round;
  assign last_o     = w_run & w_last;
  assign done_o     = r_done;

endmodule
